lane_reader: RTL and testbench

- Reader-side counterpart to the open-lane memory bank.
- Takes the flat lane bus, snapshots it on a start command, and streams a contiguous run of lanes out one per transfer over a valid/ready handshake.
- Streaming starts at a base lane and wraps modulo NLANES.
- Used to read back register/memory banks serially into narrow consumers such as debug dump and writeback muxes.

---
 rtl/lane_pkg.sv | 20 ++
 rtl/lane_mux.sv | 21 ++
 rtl/lane_reader.sv | 104 ++++++++++
 tb/tb_lane_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared types and helpers for flat lane-bus producers and consumers.
package lane_pkg;

   localparam int LANE_NLANES  = 4;
   localparam int LANE_DWIDTH  = 8;
   // Upper bounds for the generic slice helper; callers zero-extend into these.
   localparam int LANE_BUS_MAX = 1024;
   localparam int LANE_DW_MAX  = 64;

   typedef enum logic [1:0] {IDLE, STREAM, DONE} lane_state_e;

   function automatic logic [LANE_DW_MAX-1:0] lane_slice(
      input logic [LANE_BUS_MAX-1:0] bus,
      input int                      idx,
      input int                      dw
   );
      lane_slice = LANE_DW_MAX'(bus >> (idx * dw)) & ((LANE_DW_MAX'(1) << dw) - LANE_DW_MAX'(1));
   endfunction

endpackage

// File: rtl/lane_mux.sv
// Combinational NLANES:1 lane selector over a flat lane bus.
module lane_mux
   import lane_pkg::*;
#(
   parameter  int NLANES = LANE_NLANES,
   parameter  int DWIDTH = LANE_DWIDTH,
   localparam int LW     = $clog2(NLANES)
) (
   input  logic [DWIDTH*NLANES-1:0] i_bus,
   input  logic [LW-1:0]            i_sel,
   output logic [DWIDTH-1:0]        o_data
);

   logic [LANE_BUS_MAX-1:0] bus_ext;

   always_comb begin
      bus_ext = LANE_BUS_MAX'(i_bus);
      o_data  = DWIDTH'(lane_slice(bus_ext, int'(i_sel), DWIDTH));
   end

endmodule

// File: rtl/lane_reader.sv
// Streams a contiguous, wrapping run of lanes from a flat bus over valid/ready.
// Define LANE_READER_LIVE_EN to drop the snapshot and read lanes live.
module lane_reader
   import lane_pkg::*;
#(
   parameter  int NLANES = LANE_NLANES,
   parameter  int DWIDTH = LANE_DWIDTH,
   localparam int LW     = $clog2(NLANES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [LW-1:0]            i_base,
   input  logic [LW:0]              i_len,
   input  logic [DWIDTH*NLANES-1:0] i_datalane,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [DWIDTH-1:0]        o_data,
   output logic [LW-1:0]            o_lane,
   output logic                     o_last,
   output logic                     o_busy,
   output logic                     o_done
);

   lane_state_e              state_q, state_d;
   logic [LW-1:0]            idx_q, idx_d;
   logic [LW:0]              rem_q, rem_d;
   logic [LW:0]              eff_len;
   logic                     accept;
   logic [DWIDTH*NLANES-1:0] mux_bus;
   logic [DWIDTH-1:0]        mux_data;

`ifdef LANE_READER_LIVE_EN
   assign mux_bus = i_datalane;
`else
   logic [DWIDTH*NLANES-1:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (accept) shadow_d = i_datalane;
   end

   always_ff @(posedge clk) begin
      if (rst) shadow_q <= '0;
      else     shadow_q <= shadow_d;
   end

   assign mux_bus = shadow_q;
`endif

   lane_mux #(.NLANES(NLANES), .DWIDTH(DWIDTH)) u_mux (
      .i_bus  (mux_bus),
      .i_sel  (idx_q),
      .o_data (mux_data)
   );

   assign accept = (state_q == IDLE) && i_start;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      eff_len = (i_len > (LW+1)'(NLANES)) ? (LW+1)'(NLANES) : i_len;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               idx_d   = i_base;
               rem_d   = eff_len;
               state_d = (eff_len == '0) ? DONE : STREAM;
            end
         end
         STREAM: begin
            if (i_ready) begin
               idx_d = idx_q + LW'(1);
               rem_d = rem_q - (LW+1)'(1);
               if (rem_q == (LW+1)'(1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
      end
   end

   // Outputs are gated so stale index/data never leak outside a run.
   assign o_valid = (state_q == STREAM);
   assign o_data  = o_valid ? mux_data : '0;
   assign o_lane  = o_valid ? idx_q : '0;
   assign o_last  = o_valid && (rem_q == (LW+1)'(1));
   assign o_busy  = o_valid;
   assign o_done  = (state_q == DONE);

endmodule

// File: tb/tb_lane_reader.sv
// Self-checking bench for lane_reader: directed plan steps plus randomized runs vs a beat-queue model.
module tb_lane_reader;

   localparam int NL = 4;
   localparam int DW = 8;
   localparam int LW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_start;
   logic [LW-1:0]    i_base;
   logic [LW:0]      i_len;
   logic [NL*DW-1:0] i_datalane;
   logic             i_ready;
   logic             o_valid;
   logic [DW-1:0]    o_data;
   logic [LW-1:0]    o_lane;
   logic             o_last;
   logic             o_busy;
   logic             o_done;

   int n_chk  = 0;
   int n_fail = 0;
   int stall_cfg[4];
   bit rand_stall;
   int data_mode;   // 0 hold, 1 random every cycle, 2 switch to DDCCBBAA after first beat

   lane_reader #(.NLANES(NL), .DWIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_base     (i_base),
      .i_len      (i_len),
      .i_datalane (i_datalane),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_lane     (o_lane),
      .o_last     (o_last),
      .o_busy     (o_busy),
      .o_done     (o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] lane_of(input logic [NL*DW-1:0] bus, input int k);
      return bus[k*DW +: DW];
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run(input int base, input int len, input bit poke_start);
      int               lanes[$];
      int               eff;
      int               stall;
      int               k;
      logic [NL*DW-1:0] snap;
      logic [DW-1:0]    exp_d;
      eff = (len > NL) ? NL : len;
      for (int j = 0; j < eff; j++) lanes.push_back((base + j) % NL);
      chk("idle_busy", 32'(o_busy), 0);
      snap    = i_datalane;
      i_start = 1'b1;
      i_base  = LW'(base);
      i_len   = (LW+1)'(len);
      @(negedge clk);
      i_start = 1'b0;
      k = 0;
      while (lanes.size() > 0) begin
         stall = rand_stall ? int'($urandom_range(0, 2)) : stall_cfg[k];
         for (int s = 0; s <= stall; s++) begin
`ifdef LANE_READER_LIVE_EN
            exp_d = lane_of(i_datalane, lanes[0]);
`else
            exp_d = lane_of(snap, lanes[0]);
`endif
            chk("beat_valid", 32'(o_valid), 1);
            chk("beat_data",  32'(o_data),  32'(exp_d));
            chk("beat_lane",  32'(o_lane),  32'(lanes[0]));
            chk("beat_last",  32'(o_last),  (lanes.size() == 1) ? 1 : 0);
            chk("beat_busy",  32'(o_busy),  1);
            chk("beat_done",  32'(o_done),  0);
            i_ready = (s == stall);
            if (poke_start) begin
               i_start = 1'($urandom_range(0, 1));
               i_base  = LW'($urandom);
               i_len   = (LW+1)'($urandom);
            end
            if (data_mode == 1) i_datalane = $urandom;
            if (data_mode == 2 && k == 0) i_datalane = 32'hDDCCBBAA;
            @(negedge clk);
         end
         void'(lanes.pop_front());
         k++;
      end
      i_start = 1'b0;
      i_ready = 1'($urandom_range(0, 1));
      chk("end_valid", 32'(o_valid), 0);
      chk("end_done",  32'(o_done),  1);
      chk("end_busy",  32'(o_busy),  0);
      // A start landing in the done cycle must be dropped.
      i_start = 1'b1;
      i_base  = LW'($urandom);
      i_len   = 3'd2;
      @(negedge clk);
      i_start = 1'b0;
      chk("post_done", 32'(o_done),  0);
      chk("post_vld",  32'(o_valid), 0);
   endtask

   initial begin
      rst        = 1'b1;
      i_start    = 1'b0;
      i_base     = '0;
      i_len      = '0;
      i_ready    = 1'b1;
      i_datalane = 32'h44332211;
      rand_stall = 1'b0;
      data_mode  = 0;
      foreach (stall_cfg[j]) stall_cfg[j] = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_data",  32'(o_data),  0);
      chk("rst_lane",  32'(o_lane),  0);
      chk("rst_last",  32'(o_last),  0);
      chk("rst_busy",  32'(o_busy),  0);
      chk("rst_done",  32'(o_done),  0);
      rst = 1'b0;
      @(negedge clk);

      run(0, 4, 1'b0);                          // full run
      run(3, 2, 1'b0);                          // wrap
      stall_cfg[0] = 2; stall_cfg[1] = 1;       // backpressure
      run(1, 3, 1'b0);
      stall_cfg[0] = 0; stall_cfg[1] = 0;
      data_mode = 2;                            // snapshot vs live
      run(0, 4, 1'b0);
      data_mode = 0;
      i_datalane = 32'h44332211;
      run(0, 4, 1'b1);                          // mid-run start pulses
      run(2, 0, 1'b0);                          // zero length
      run(1, 7, 1'b0);                          // clamped length

      // Reset on the second beat.
      i_start = 1'b1; i_base = 2'd0; i_len = 3'd4;
      @(negedge clk);
      i_start = 1'b0; i_ready = 1'b1;
      chk("rr_beat0", 32'(o_data), 32'h11);
      @(negedge clk);
      chk("rr_beat1", 32'(o_data), 32'h22);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rr_valid", 32'(o_valid), 0);
      chk("rr_data",  32'(o_data),  0);
      chk("rr_lane",  32'(o_lane),  0);
      chk("rr_last",  32'(o_last),  0);
      chk("rr_busy",  32'(o_busy),  0);
      chk("rr_done",  32'(o_done),  0);
      @(negedge clk);
      chk("rr_nodone", 32'(o_done), 0);
      run(2, 1, 1'b0);

      // Randomized runs with random stalls, data churn and stray starts.
      rand_stall = 1'b1;
      data_mode  = 1;
      for (int r = 0; r < 25; r++) begin
         i_datalane = $urandom;
         run(int'($urandom_range(0, NL-1)), int'($urandom_range(0, 7)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
